sw_oarb: RTL

Per-output-port wormhole arbiter for the packet switch. Each instance owns one output port, picks among the input ports whose head flit targets that port using round-robin priority, then locks the grant until the tail flit has passed. It sits between the input FIFOs and the output-side write logic, driving the FIFO dequeue strobes and the output flit/write-enable pair.

---
 rtl/sw_pkg.sv | 20 ++
 rtl/sw_oarb_rr_pick.sv | 30 +++
 rtl/sw_oarb.sv | 117 +++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared switch definitions: flit geometry, flit type codes and arbiter states.
package sw_pkg;

    localparam int NPORT    = 4;
    localparam int PKTW     = 9;
    localparam int DEST_W   = $clog2(NPORT);
    localparam int DEST_LSB = 0;

    // Flit type lives in the top two bits of every flit.
    localparam logic [1:0] FT_IDLE = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_BODY = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sw_oarb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;
    logic          found;

    // Scan upward from ptr; PW-bit addition wraps because N is a power of two.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + PW'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_oarb.sv
// Per-output-port wormhole arbiter: round-robin grant on a head flit,
// grant held until the owner's tail flit has been forwarded.
module sw_oarb #(
    parameter int NPORT   = sw_pkg::NPORT,
    parameter int PKTW    = sw_pkg::PKTW,
    parameter int PORT_ID = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORT*(PKTW+1)-1:0] pkti,
    input  logic [NPORT-1:0]          vld,
    input  logic                      rdy,
    output logic [NPORT-1:0]          deq,
    output logic [NPORT-1:0]          grant,
    output logic                      busy,
    output logic [PKTW:0]             pkto,
    output logic                      we
);

    import sw_pkg::*;

    localparam int PW = $clog2(NPORT);

    arb_state_t     state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NPORT-1:0] grant_d;
    logic [PKTW:0]  pkto_d;
    logic           we_d;

    logic [PKTW:0]    flits [NPORT];
    logic [NPORT-1:0] req;
    logic [NPORT-1:0] pick;
    logic [PKTW:0]    owner_flit;
    logic [PW-1:0]    owner_idx;
    logic             xfer;

    // Unpack head flits and form requests: valid head flits addressed to this port.
    always_comb begin
        req = '0;
        for (int i = 0; i < NPORT; i++) begin
            flits[i] = pkti[i*(PKTW+1) +: (PKTW+1)];
            req[i]   = vld[i] && (flits[i][PKTW -: 2] == FT_HEAD) &&
                       (flits[i][DEST_LSB +: PW] == PW'(PORT_ID));
        end
    end

    rr_pick #(.N(NPORT)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick)
    );

    // Select the owner's flit and index from the one-hot grant register.
    always_comb begin
        owner_flit = '0;
        owner_idx  = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant[i]) begin
                owner_flit = flits[i];
                owner_idx  = PW'(i);
            end
        end
    end

    // Pop strobe depends only on registered grant, vld and rdy, never on flit contents.
    assign deq  = (state_q == ST_BUSY) ? (grant & vld & {NPORT{rdy}}) : '0;
    assign xfer = |deq;
    assign busy = (state_q == ST_BUSY);

    // Next-state: arbitrate in IDLE, forward owner flits in BUSY, release on tail.
    always_comb begin
        state_d = state_q;
        grant_d = grant;
        ptr_d   = ptr_q;
        pkto_d  = pkto;
        we_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (xfer) begin
                    pkto_d = owner_flit;
                    we_d   = 1'b1;
                    if (owner_flit[PKTW -: 2] == FT_TAIL) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = owner_idx + PW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant   <= '0;
            pkto    <= '0;
            we      <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant   <= grant_d;
            pkto    <= pkto_d;
            we      <= we_d;
        end
    end

endmodule
